// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI-Lite register arbiter.
package axil_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_BRESP,
        ST_RADDR,
        ST_RDATA,
        ST_RESP
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: the requester not granted last wins a tie.
module rr_arbiter2 (
    input  logic       i_clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic       grant_o
);

    logic last_grant_q;

    // On a tie favour the other requester; otherwise grant whoever is asking.
    always_comb begin
        grant_o = req_i[1];
        if (req_i == 2'b11) begin
            grant_o = ~last_grant_q;
        end
    end

    // Remember the winner only when the grant is actually taken.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else if (accept_i) begin
            last_grant_q <= grant_o;
        end
    end

endmodule

// File: rtl/axil_reg_arbiter.sv
// Arbitrates two register requesters onto one AXI-Lite master port,
// one transaction outstanding at a time.
module axil_reg_arbiter
    import axil_pkg::*;
#(
    parameter int C_AXI_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int C_AXI_ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                            i_clk,
    input  logic                            reset,
    input  logic [1:0]                      req_valid,
    input  logic [1:0]                      req_write,
    input  logic [2*C_AXI_ADDR_WIDTH-1:0]   req_addr,
    input  logic [2*C_AXI_DATA_WIDTH-1:0]   req_wdata,
    input  logic [2*C_AXI_DATA_WIDTH/8-1:0] req_wstrb,
    output logic [1:0]                      req_ready,
    output logic [1:0]                      rsp_valid,
    output logic [C_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            m_awvalid,
    input  logic                            m_awready,
    output logic [C_AXI_ADDR_WIDTH-1:0]     m_awaddr,
    output logic                            m_wvalid,
    input  logic                            m_wready,
    output logic [C_AXI_DATA_WIDTH-1:0]     m_wdata,
    output logic [C_AXI_DATA_WIDTH/8-1:0]   m_wstrb,
    input  logic                            m_bvalid,
    output logic                            m_bready,
    input  logic [1:0]                      m_bresp,
    output logic                            m_arvalid,
    input  logic                            m_arready,
    output logic [C_AXI_ADDR_WIDTH-1:0]     m_araddr,
    input  logic                            m_rvalid,
    output logic                            m_rready,
    input  logic [C_AXI_DATA_WIDTH-1:0]     m_rdata,
    input  logic [1:0]                      m_rresp
);

    localparam int DW = C_AXI_DATA_WIDTH;
    localparam int AW = C_AXI_ADDR_WIDTH;
    localparam int SW = DW / 8;

    state_e          state_q, state_d;
    logic            grant_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [SW-1:0]   wstrb_q;
    logic            aw_done_q;
    logic            w_done_q;
    logic [DW-1:0]   rdata_q;
    logic [1:0]      resp_q;

    logic            arb_grant;
    logic            accept;

    // A grant is only taken in IDLE; requests while busy are ignored.
    assign accept = (state_q == ST_IDLE) && (|req_valid);

    rr_arbiter2 u_arb (
        .i_clk    (i_clk),
        .reset    (reset),
        .req_i    (req_valid),
        .accept_i (accept),
        .grant_o  (arb_grant)
    );

    assign m_awaddr  = addr_q;
    assign m_araddr  = addr_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;

    // Next-state and handshake outputs; AW and W drop independently once taken.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        rsp_valid = '0;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    req_ready[arb_grant] = 1'b1;
                    state_d = req_write[arb_grant] ? ST_WRITE : ST_RADDR;
                end
            end
            ST_WRITE: begin
                m_awvalid = !aw_done_q;
                m_wvalid  = !w_done_q;
                if ((aw_done_q || m_awready) && (w_done_q || m_wready)) begin
                    state_d = ST_BRESP;
                end
            end
            ST_BRESP: begin
                m_bready = 1'b1;
                if (m_bvalid) state_d = ST_RESP;
            end
            ST_RADDR: begin
                m_arvalid = 1'b1;
                if (m_arready) state_d = ST_RDATA;
            end
            ST_RDATA: begin
                m_rready = 1'b1;
                if (m_rvalid) state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid[grant_q] = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, latched request payload, handshake progress and captured response.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        grant_q   <= arb_grant;
                        addr_q    <= req_addr[int'(arb_grant)*AW +: AW];
                        wdata_q   <= req_wdata[int'(arb_grant)*DW +: DW];
                        wstrb_q   <= req_wstrb[int'(arb_grant)*SW +: SW];
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    if (m_awvalid && m_awready) aw_done_q <= 1'b1;
                    if (m_wvalid && m_wready)   w_done_q  <= 1'b1;
                end
                ST_BRESP: begin
                    if (m_bvalid) begin
                        resp_q  <= m_bresp;
                        rdata_q <= '0;
                    end
                end
                ST_RDATA: begin
                    if (m_rvalid) begin
                        resp_q  <= m_rresp;
                        rdata_q <= m_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_reg_arbiter.sv
// Directed bench for axil_reg_arbiter with a small configurable AXI-Lite slave.
module tb_axil_reg_arbiter;
    import axil_pkg::*;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid, req_write;
    logic [3:0]  req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic [1:0]  req_ready, rsp_valid, rsp_resp;
    logic [31:0] rsp_rdata;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [1:0]  m_awaddr, m_araddr, m_bresp, m_rresp;
    logic [31:0] m_wdata, m_rdata;
    logic [3:0]  m_wstrb;

    axil_reg_arbiter #(.C_AXI_DATA_WIDTH(32), .C_AXI_ADDR_WIDTH(2)) dut (
        .i_clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- slave model ----------------
    int          aw_dly = 0, w_dly = 0, aw_cnt, w_cnt;
    logic [1:0]  bresp_cfg = RESP_OKAY, rresp_cfg = RESP_OKAY;
    logic        rd_ovr_en = 1'b0;
    logic [31:0] rd_ovr = '0;
    logic [31:0] mem [4];
    logic        aw_got, w_got;
    logic [1:0]  aw_addr_l;
    logic [31:0] w_data_l;
    logic [3:0]  w_strb_l;
    logic        aw_hs, w_hs, ar_hs;
    logic [1:0]  wa;
    logic [31:0] wd;
    logic [3:0]  ws;

    assign m_awready = m_awvalid && (aw_cnt >= aw_dly);
    assign m_wready  = m_wvalid && (w_cnt >= w_dly);
    assign m_arready = m_arvalid;
    assign aw_hs = m_awvalid && m_awready;
    assign w_hs  = m_wvalid && m_wready;
    assign ar_hs = m_arvalid && m_arready;
    assign wa = aw_hs ? m_awaddr : aw_addr_l;
    assign wd = w_hs ? m_wdata : w_data_l;
    assign ws = w_hs ? m_wstrb : w_strb_l;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
            aw_addr_l <= '0; w_data_l <= '0; w_strb_l <= '0;
            m_bvalid <= 1'b0; m_bresp <= '0; m_rvalid <= 1'b0; m_rdata <= '0; m_rresp <= '0;
            for (int i = 0; i < 4; i++) mem[i] <= '0;
        end else begin
            aw_cnt <= (m_awvalid && !m_awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (m_wvalid && !m_wready) ? w_cnt + 1 : 0;
            if (aw_hs) begin aw_got <= 1'b1; aw_addr_l <= m_awaddr; end
            if (w_hs) begin w_got <= 1'b1; w_data_l <= m_wdata; w_strb_l <= m_wstrb; end
            if ((aw_got || aw_hs) && (w_got || w_hs) && !m_bvalid) begin
                m_bvalid <= 1'b1; m_bresp <= bresp_cfg;
                aw_got <= 1'b0; w_got <= 1'b0;
                mem[wa] <= merge(mem[wa], wd, ws);
            end
            if (m_bvalid && m_bready) m_bvalid <= 1'b0;
            if (ar_hs) begin
                m_rvalid <= 1'b1;
                m_rdata  <= rd_ovr_en ? rd_ovr : mem[m_araddr];
                m_rresp  <= rresp_cfg;
            end
            if (m_rvalid && m_rready) m_rvalid <= 1'b0;
        end
    end

    // ---------------- checking ----------------
    int total = 0, bad = 0;

    logic [82:0] outs;
    assign outs = {req_ready, rsp_valid, rsp_rdata, rsp_resp, m_awvalid, m_awaddr, m_wvalid,
                   m_wdata, m_wstrb, m_bready, m_arvalid, m_araddr, m_rready};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic fail_to(input string name);
        total++;
        bad++;
        $display("FAIL %s timed out", name);
    endtask

    typedef struct {
        logic        port;
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          aw_dly;
        int          w_dly;
        logic [1:0]  bresp;
        logic [1:0]  rresp;
        logic        ovr;
        logic [31:0] ovr_data;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        int          exp_cyc;   // rsp cycle, counting the acceptance cycle as 1
    } vec_t;

    task automatic drive_req(input logic port, input logic wr, input logic [1:0] addr,
                             input logic [31:0] wdata, input logic [3:0] strb);
        req_valid = '0;
        req_valid[port] = 1'b1;
        req_write[port] = wr;
        req_addr[int'(port)*2 +: 2]   = addr;
        req_wdata[int'(port)*32 +: 32] = wdata;
        req_wstrb[int'(port)*4 +: 4]  = strb;
    endtask

    task automatic wait_accept(input string tag, input logic port, output int t);
        t = -1;
        for (int n = 0; n < 10 && t < 0; n++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                t = cyc;
                chk({tag, "_ready"}, req_ready, port ? 2'b10 : 2'b01);
            end
        end
        if (t < 0) fail_to({tag, "_accept"});
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int t_acc, t_rsp;
        aw_dly = v.aw_dly; w_dly = v.w_dly; bresp_cfg = v.bresp; rresp_cfg = v.rresp;
        rd_ovr_en = v.ovr; rd_ovr = v.ovr_data;
        @(posedge clk); #1;
        drive_req(v.port, v.wr, v.addr, v.wdata, v.strb);
        wait_accept(tag, v.port, t_acc);
        @(posedge clk); #1;
        req_valid = '0;
        if (t_acc < 0) return;
        t_rsp = -1;
        for (int n = 0; n < 20 && t_rsp < 0; n++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) begin
                t_rsp = cyc;
                chk({tag, "_rsp_port"}, rsp_valid, v.port ? 2'b10 : 2'b01);
                chk({tag, "_rdata"}, rsp_rdata, v.exp_rdata);
                chk({tag, "_resp"}, rsp_resp, v.exp_resp);
            end
        end
        if (t_rsp < 0) fail_to({tag, "_rsp"});
        else begin
            chk({tag, "_latency"}, t_rsp - t_acc + 1, v.exp_cyc);
            @(negedge clk);
            chk({tag, "_pulse"}, rsp_valid, 2'b00);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    vec_t vt [10];

    initial begin
        int t_acc, cnt;
        logic [4:0] ex [5];
        logic [1:0] grants [4];
        logic       seen;

        reset = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;

        vt[0] = '{1'b0, 1'b1, 2'd2, 32'hA5A5_1234, 4'hF, 0, 0, RESP_OKAY, RESP_OKAY, 1'b0, 32'h0, 32'h0, RESP_OKAY, 4};
        vt[1] = '{1'b0, 1'b0, 2'd2, 32'h0, 4'h0, 0, 0, RESP_OKAY, RESP_OKAY, 1'b0, 32'h0, 32'hA5A5_1234, RESP_OKAY, 4};
        vt[2] = '{1'b1, 1'b1, 2'd1, 32'h1122_3344, 4'b0101, 0, 0, RESP_OKAY, RESP_OKAY, 1'b0, 32'h0, 32'h0, RESP_OKAY, 4};
        vt[3] = '{1'b1, 1'b0, 2'd1, 32'h0, 4'h0, 0, 0, RESP_OKAY, RESP_OKAY, 1'b0, 32'h0, 32'h0022_0044, RESP_OKAY, 4};
        vt[4] = '{1'b1, 1'b0, 2'd3, 32'h0, 4'h0, 0, 0, RESP_OKAY, RESP_SLVERR, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, RESP_SLVERR, 4};
        vt[5] = '{1'b0, 1'b1, 2'd0, 32'hFFFF_0000, 4'hF, 0, 0, RESP_SLVERR, RESP_OKAY, 1'b0, 32'h0, 32'h0, RESP_SLVERR, 4};
        vt[6] = '{1'b1, 1'b1, 2'd3, 32'hCAFE_F00D, 4'hF, 3, 0, RESP_OKAY, RESP_OKAY, 1'b0, 32'h0, 32'h0, RESP_OKAY, 7};
        vt[7] = '{1'b0, 1'b1, 2'd3, 32'h0000_00AB, 4'b0001, 0, 2, RESP_OKAY, RESP_OKAY, 1'b0, 32'h0, 32'h0, RESP_OKAY, 6};
        vt[8] = '{1'b0, 1'b0, 2'd3, 32'h0, 4'h0, 0, 0, RESP_OKAY, RESP_OKAY, 1'b0, 32'h0, 32'hCAFE_F0AB, RESP_OKAY, 4};
        vt[9] = '{1'b1, 1'b0, 2'd0, 32'h0, 4'h0, 0, 0, RESP_OKAY, RESP_OKAY, 1'b0, 32'h0, 32'hFFFF_0000, RESP_OKAY, 4};

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", outs, 83'h0);
        @(posedge clk); #1 reset = 1'b0;

        for (int i = 0; i < 10; i++) run_txn(vt[i], $sformatf("v%0d", i));

        // W accepted three cycles before AW
        aw_dly = 3; w_dly = 0; bresp_cfg = RESP_OKAY;
        ex = '{5'b110_01, 5'b100_01, 5'b100_01, 5'b100_01, 5'b001_01};
        @(posedge clk); #1;
        drive_req(1'b0, 1'b1, 2'd1, 32'h1357_9BDF, 4'hF);
        wait_accept("awlag", 1'b0, t_acc);
        @(posedge clk); #1;
        req_valid = '0;
        if (t_acc >= 0) begin
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                chk($sformatf("awlag_c%0d", k + 1), {m_awvalid, m_wvalid, m_bready, m_awaddr}, ex[k]);
            end
        end
        repeat (4) @(posedge clk);

        // both requesters held valid: grants alternate from requester 0
        do_reset();
        aw_dly = 0; w_dly = 0; rd_ovr_en = 1'b0; rresp_cfg = RESP_OKAY;
        req_write = 2'b00; req_addr = 4'b01_10;
        req_valid = 2'b11;
        cnt = 0;
        for (int n = 0; n < 60 && cnt < 4; n++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                grants[cnt] = req_ready;
                cnt++;
            end
        end
        @(posedge clk); #1 req_valid = '0;
        if (cnt < 4) fail_to("rr_grants");
        else begin
            chk("rr_g0", grants[0], 2'b01);
            chk("rr_g1", grants[1], 2'b10);
            chk("rr_g2", grants[2], 2'b01);
            chk("rr_g3", grants[3], 2'b10);
        end
        repeat (6) @(posedge clk);

        // reset in BRESP abandons the write
        do_reset();
        @(posedge clk); #1;
        drive_req(1'b1, 1'b1, 2'd0, 32'h5A5A_5A5A, 4'hF);
        wait_accept("rstb", 1'b1, t_acc);
        @(posedge clk); #1;
        req_valid = '0;
        if (t_acc >= 0) begin
            @(posedge clk); #1 reset = 1'b1;
            @(negedge clk);
            chk("rstb_in_bresp", m_bready, 1'b1);
            @(posedge clk); #1 reset = 1'b0;
            @(negedge clk);
            chk("rstb_outputs", outs, 83'h0);
            seen = 1'b0;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                seen = seen | (|rsp_valid);
            end
            chk("rstb_no_rsp", seen, 1'b0);
        end
        run_txn('{1'b0, 1'b1, 2'd1, 32'h0BAD_F00D, 4'hF, 0, 0, RESP_OKAY, RESP_OKAY, 1'b0, 32'h0, 32'h0, RESP_OKAY, 4}, "post_w");
        run_txn('{1'b0, 1'b0, 2'd1, 32'h0, 4'h0, 0, 0, RESP_OKAY, RESP_OKAY, 1'b0, 32'h0, 32'h0BAD_F00D, RESP_OKAY, 4}, "post_r");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axil_reg_arbiter.md
AXIL_REG_ARBITER -- requirements
Module: axil_reg_arbiter

Interface
REQ-001 Parameter C_AXI_DATA_WIDTH, default 32, data width of the requester ports and the AXI-Lite master port.
REQ-002 Parameter C_AXI_ADDR_WIDTH, default 2, register address width (4 word registers).
REQ-003 i_clk  input  1  system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  2  per-requester transaction request; bit n belongs to requester n.
REQ-006 req_write  input  2  per-requester direction; 1 = write, 0 = read.
REQ-007 req_addr  input  2*AW  per-requester address; requester n uses slice [n*AW +: AW].
REQ-008 req_wdata  input  2*DW  per-requester write data.
REQ-009 req_wstrb  input  2*DW/8  per-requester byte strobes.
REQ-010 req_ready  output  2  one-cycle pulse: request from requester n accepted.
REQ-011 rsp_valid  output  2  one-cycle pulse: response for requester n is valid.
REQ-012 rsp_rdata  output  DW  read data; valid with rsp_valid; zero for writes.
REQ-013 rsp_resp  output  2  captured BRESP or RRESP; valid with rsp_valid.
REQ-014 m_awvalid / m_awready  output / input  1 / 1  AXI-Lite write-address handshake.
REQ-015 m_awaddr  output  AW  write address.
REQ-016 m_wvalid / m_wready  output / input  1 / 1  write-data handshake.
REQ-017 m_wdata / m_wstrb  output  DW / DW/8  write data and strobes.
REQ-018 m_bvalid / m_bready  input / output  1 / 1  write-response handshake.
REQ-019 m_bresp  input  2  write response code.
REQ-020 m_arvalid / m_arready  output / input  1 / 1  read-address handshake.
REQ-021 m_araddr  output  AW  read address.
REQ-022 m_rvalid / m_rready  input / output  1 / 1  read-data handshake.
REQ-023 m_rdata / m_rresp  input  DW / 2  read data and read response code.

Function
REQ-024 FSM states: IDLE, WRITE (AW+W), BRESP, RADDR, RDATA, RESP.
REQ-025 In IDLE with any req_valid set: grant by round-robin.
- Priority to the requester not granted last.
- last_grant resets to 1, so requester 0 wins the first tie.
- Pulse req_ready[grant].
- Latch write, addr, wdata and wstrb.
- Next state WRITE or RADDR.
REQ-026 WRITE:
- Assert m_awvalid and m_wvalid together on the first cycle.
- Deassert each independently after its own handshake.
- Go to BRESP when both handshakes are done, in either order or simultaneously.
- AW and W payloads stay stable while their valid is high.
REQ-027 BRESP: m_bready=1; on m_bvalid capture m_bresp, go to RESP.
REQ-028 RADDR: m_arvalid=1 until m_arready, then RDATA.
REQ-029 RDATA: m_rready=1; on m_rvalid capture m_rdata and m_rresp, go to RESP.
REQ-030 RESP: pulse rsp_valid[grant] for exactly one cycle with the captured data; go to IDLE.
- The requester cannot stall the response.
REQ-031 Timing and arbitration rules:
- Minimum latency, acceptance to rsp_valid: 4 cycles with a zero-wait slave.
- Only one transaction outstanding.
- req_valid changes while busy are ignored until the next IDLE.

Reset
REQ-032 reset forces IDLE and sets last_grant=1.
- All valid, ready and rsp outputs are 0; captured data is 0.
- Reset mid-transaction abandons it; no rsp_valid is issued.

Structure
REQ-033 Shared package axil_pkg: state enum, AXI response codes (OKAY=2'b00, SLVERR=2'b10), default widths.
REQ-034 Single sub-module rr_arbiter2 (2-way round-robin grant and last_grant register); everything else stays inline.

Verification
REQ-035 Req0 writes addr 2, data 0xA5A5_1234, strb 4'hF, zero-wait slave -> rsp_valid[0] at cycle 4, rsp_resp=0; a read of addr 2 returns 0xA5A5_1234.
REQ-036 Both requesters valid continuously -> grants alternate 0,1,0,1; no requester is granted twice in a row.
REQ-037 m_wready asserted 3 cycles before m_awready -> m_wvalid drops first, m_awvalid holds, then BRESP is entered once both are done.
REQ-038 Slave returns m_rresp=2'b10 with m_rdata=0xDEAD_BEEF -> rsp_resp=2'b10, rsp_rdata=0xDEAD_BEEF on the granted port only.
REQ-039 reset asserted during BRESP -> next cycle all outputs are 0, FSM is IDLE, no rsp_valid; after release a new request completes normally.
